// File: rtl/dispatcher_pkg.sv
// Shared route encodings and lane FIFO sizing for the 1-to-2 dispatcher.
package dispatcher_pkg;

    localparam logic [1:0] DEST_DROP  = 2'b00;
    localparam logic [1:0] DEST_LANE0 = 2'b01;
    localparam logic [1:0] DEST_LANE1 = 2'b10;
    localparam logic [1:0] DEST_ANY   = 2'b11;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/fifo_2entry.sv
// Two-entry lane FIFO; slot0 is always the head, full/empty from registered occupancy.
module fifo_2entry
    import dispatcher_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0]     slot0_q, slot0_d;
    logic [DWIDTH-1:0]     slot1_q, slot1_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = slot0_q;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == '0) slot0_d = data_i;
                else               slot1_d = data_i;
                count_d = count_q + FIFO_CNT_W'(1);
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - FIFO_CNT_W'(1);
            end
            // Push needs a non-full FIFO and pop a non-empty one, so occupancy is exactly 1 here.
            2'b11:   slot0_d = data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dispatcher_1to2.sv
// Routes input beats to one of two buffered lanes, round-robins "either" beats, counts drops.
module dispatcher_1to2
    import dispatcher_pkg::*;
#(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DWIDTH-1:0]     in_data,
    input  logic [1:0]            in_dest,
    output logic                  in_ready,
    output logic                  out_0_valid,
    output logic [DWIDTH-1:0]     out_0_data,
    input  logic                  out_0_ready,
    output logic                  out_1_valid,
    output logic [DWIDTH-1:0]     out_1_data,
    input  logic                  out_1_ready,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic                  full0, full1;
    logic                  empty0, empty1;
    logic                  push0, push1;
    logic                  accept;
    logic                  any_sel;
    logic                  rr_q, rr_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    assign out_0_valid = ~empty0;
    assign out_1_valid = ~empty1;
    assign drop_count  = drop_q;
    assign accept      = in_valid & in_ready;

    // Readiness looks only at registered fullness, so downstream ready never reaches in_ready.
    always_comb begin
        in_ready = 1'b1;
        case (in_dest)
            DEST_LANE0: in_ready = ~full0;
            DEST_LANE1: in_ready = ~full1;
            DEST_ANY:   in_ready = ~full0 | ~full1;
            default:    in_ready = 1'b1;
        endcase
    end

    always_comb begin
        push0   = 1'b0;
        push1   = 1'b0;
        rr_d    = rr_q;
        drop_d  = drop_q;
        any_sel = rr_q ? ~full1 : full0;
        if (accept) begin
            case (in_dest)
                DEST_LANE0: push0 = 1'b1;
                DEST_LANE1: push1 = 1'b1;
                DEST_ANY: begin
                    push0 = ~any_sel;
                    push1 = any_sel;
                    rr_d  = ~any_sel;
                end
                default: begin
                    if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q   <= 1'b0;
            drop_q <= '0;
        end else begin
            rr_q   <= rr_d;
            drop_q <= drop_d;
        end
    end

    fifo_2entry #(.DWIDTH(DWIDTH)) u_lane0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push0),
        .data_i  (in_data),
        .pop_i   (out_0_ready),
        .full_o  (full0),
        .empty_o (empty0),
        .head_o  (out_0_data)
    );

    fifo_2entry #(.DWIDTH(DWIDTH)) u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push1),
        .data_i  (in_data),
        .pop_i   (out_1_ready),
        .full_o  (full1),
        .empty_o (empty1),
        .head_o  (out_1_data)
    );

endmodule

// File: tb/tb_dispatcher_1to2.sv
// Directed bench for dispatcher_1to2 with a narrow drop counter to reach saturation.
module tb_dispatcher_1to2;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_ready;
    logic          out_0_valid, out_1_valid;
    logic [DW-1:0] out_0_data, out_1_data;
    logic          out_0_ready, out_1_ready;
    logic [CW-1:0] drop_count;

    int n_checks = 0;
    int n_fails  = 0;

    dispatcher_1to2 #(.DWIDTH(DW), .DROP_CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_dest     (in_dest),
        .in_ready    (in_ready),
        .out_0_valid (out_0_valid),
        .out_0_data  (out_0_data),
        .out_0_ready (out_0_ready),
        .out_1_valid (out_1_valid),
        .out_1_data  (out_1_data),
        .out_1_ready (out_1_ready),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [1:0] d, input logic [DW-1:0] x);
        in_valid = v;
        in_dest  = d;
        in_data  = x;
    endtask

    initial begin
        rst = 1'b1;
        offer(1'b0, 2'b00, 8'h00);
        out_0_ready = 1'b0;
        out_1_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Cleared state
        chk("rst_v0",  32'(out_0_valid), 0);
        chk("rst_v1",  32'(out_1_valid), 0);
        chk("rst_d0",  32'(out_0_data), 0);
        chk("rst_d1",  32'(out_1_data), 0);
        chk("rst_drop", 32'(drop_count), 0);
        for (int d = 0; d < 4; d++) begin
            in_dest = 2'(d);
            #1;
            chk($sformatf("rst_rdy_dest%0d", d), 32'(in_ready), 1);
        end
        step();

        // Single lane-0 beat, latency 1
        out_0_ready = 1'b1;
        offer(1'b1, 2'b01, 8'hA5);
        #1 chk("l0_rdy", 32'(in_ready), 1);
        step();
        offer(1'b0, 2'b01, 8'h00);
        chk("l0_v0", 32'(out_0_valid), 1);
        chk("l0_d0", 32'(out_0_data), 'hA5);
        chk("l0_v1", 32'(out_1_valid), 0);
        step();
        chk("l0_popped", 32'(out_0_valid), 0);

        // Lane 1 backpressure and refill after pop
        out_1_ready = 1'b0;
        offer(1'b1, 2'b10, 8'h01);
        #1 chk("bp_rdy1", 32'(in_ready), 1);
        step();
        offer(1'b1, 2'b10, 8'h02);
        #1 chk("bp_rdy2", 32'(in_ready), 1);
        step();
        offer(1'b1, 2'b10, 8'h03);
        #1 chk("bp_rdy3", 32'(in_ready), 0);
        chk("bp_head1", 32'(out_1_data), 'h01);
        out_1_ready = 1'b1;
        step();
        chk("bp_head2", 32'(out_1_data), 'h02);
        chk("bp_rdy_after_pop", 32'(in_ready), 1);
        step();
        offer(1'b0, 2'b10, 8'h00);
        chk("bp_v_last", 32'(out_1_valid), 1);
        chk("bp_head3", 32'(out_1_data), 'h03);
        step();
        chk("bp_empty", 32'(out_1_valid), 0);

        // Round-robin of "either" beats
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 2'b11, 8'(8'h10 + i));
            #1 chk($sformatf("rr_rdy%0d", i), 32'(in_ready), 1);
            step();
            if (i % 2 == 0) begin
                chk($sformatf("rr_v0_%0d", i), 32'(out_0_valid), 1);
                chk($sformatf("rr_d0_%0d", i), 32'(out_0_data), 32'(8'h10 + i));
                chk($sformatf("rr_nv1_%0d", i), 32'(out_1_valid), 0);
            end else begin
                chk($sformatf("rr_v1_%0d", i), 32'(out_1_valid), 1);
                chk($sformatf("rr_d1_%0d", i), 32'(out_1_data), 32'(8'h10 + i));
                chk($sformatf("rr_nv0_%0d", i), 32'(out_0_valid), 0);
            end
        end
        offer(1'b0, 2'b11, 8'h00);
        step();

        // Drops with saturating 2-bit counter
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 2'b00, 8'(8'hE0 + i));
            #1 chk($sformatf("drop_rdy%0d", i), 32'(in_ready), 1);
            step();
            chk($sformatf("drop_cnt%0d", i), 32'(drop_count), (i < 3) ? i + 1 : 3);
            chk($sformatf("drop_v0_%0d", i), 32'(out_0_valid), 0);
            chk($sformatf("drop_v1_%0d", i), 32'(out_1_valid), 0);
        end

        // Lane 0 full: "either" beat diverts to lane 1
        out_0_ready = 1'b0;
        out_1_ready = 1'b0;
        offer(1'b1, 2'b01, 8'h20);
        step();
        offer(1'b1, 2'b01, 8'h21);
        step();
        offer(1'b1, 2'b11, 8'h77);
        #1 chk("div_rdy", 32'(in_ready), 1);
        step();
        offer(1'b0, 2'b11, 8'h00);
        chk("div_v1", 32'(out_1_valid), 1);
        chk("div_d1", 32'(out_1_data), 'h77);
        chk("div_d0", 32'(out_0_data), 'h20);
        out_0_ready = 1'b1;
        step();
        out_0_ready = 1'b0;
        // rr_ptr should be back on lane 0, so this beat lands there
        offer(1'b1, 2'b11, 8'h78);
        step();
        offer(1'b0, 2'b01, 8'h00);
        #1 chk("rr_back_l0_full", 32'(in_ready), 0);
        in_dest = 2'b10;
        #1 chk("rr_back_l1_space", 32'(in_ready), 1);
        offer(1'b1, 2'b10, 8'h79);
        step();
        offer(1'b0, 2'b11, 8'h00);
        #1 chk("both_full_any", 32'(in_ready), 0);
        in_dest = 2'b10;
        #1 chk("both_full_l1", 32'(in_ready), 0);
        in_dest = 2'b00;
        #1 chk("both_full_drop", 32'(in_ready), 1);
        chk("full_head0", 32'(out_0_data), 'h21);
        chk("full_head1", 32'(out_1_data), 'h77);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("arst_v0", 32'(out_0_valid), 0);
        chk("arst_v1", 32'(out_1_valid), 0);
        chk("arst_d0", 32'(out_0_data), 0);
        chk("arst_drop", 32'(drop_count), 0);
        step();
        rst = 1'b0;
        out_0_ready = 1'b1;
        out_1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_v0_%0d", i), 32'(out_0_valid), 0);
            chk($sformatf("post_v1_%0d", i), 32'(out_1_valid), 0);
        end
        out_0_ready = 1'b0;
        out_1_ready = 1'b0;
        offer(1'b1, 2'b11, 8'hA0);
        step();
        offer(1'b0, 2'b00, 8'h00);
        chk("post_rr_v0", 32'(out_0_valid), 1);
        chk("post_rr_d0", 32'(out_0_data), 'hA0);
        chk("post_rr_v1", 32'(out_1_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dispatcher_1to2.md
DISPATCHER_1TO2 -- requirements
Module: dispatcher_1to2

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: width of the data payload.
REQ-002 SHALL have parameter DROP_CNT_W, default 16: width of the drop counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: an input beat is offered.
REQ-006 SHALL have port in_data, input, DWIDTH: the input payload.
REQ-007 SHALL have port in_dest, input, 2: route code: 01 = lane 0, 10 = lane 1, 11 = either lane, 00 = discard.
REQ-008 SHALL have port in_ready, output, 1: the dispatcher accepts the beat.
REQ-009 SHALL have ports out_0_valid/out_1_valid, output, 1 each: the lane holds a beat.
REQ-010 SHALL have ports out_0_data/out_1_data, output, DWIDTH each: the lane head payload.
REQ-011 SHALL have ports out_0_ready/out_1_ready, input, 1 each: the downstream consumer accepts.
REQ-012 SHALL have port drop_count, output, DROP_CNT_W: count of discarded beats.

Function
REQ-013 Transfers SHALL occur only on valid&ready, on each port.
REQ-014 Each lane SHALL own a 2-entry FIFO; out_k_valid = FIFO not empty; out_k_data = FIFO head.
REQ-015 Full flags SHALL come from registered occupancy only. No combinational path from out_k_ready to in_ready; a pop does not free space in the same cycle.
REQ-016 in_ready SHALL be set by in_dest:
  - 01 -> ~full0
  - 10 -> ~full1
  - 11 -> ~full0 | ~full1
  - 00 -> 1
REQ-017 An accepted beat with in_dest 01 or 10 SHALL be pushed into the named lane, visible on its outputs the next cycle (latency 1).
REQ-018 For an accepted beat with in_dest 11, the target SHALL be lane rr_ptr if that lane is not full, else the other lane.
REQ-019 After each accepted 11 beat, rr_ptr SHALL be set to the lane not chosen. rr_ptr SHALL be unchanged by 01, 10 and 00 beats.
REQ-020 An accepted beat with in_dest 00 SHALL be discarded. drop_count SHALL increment by 1 and saturate at all-ones.
REQ-021 A simultaneous push and pop on one lane SHALL leave occupancy unchanged and keep FIFO order.
REQ-022 A pop on an empty lane SHALL be impossible by construction, since out_k_valid = 0.
REQ-023 in_data SHALL be ignored when in_valid = 0. A beat held with in_ready = 0 SHALL not change state.
REQ-024 Beat order SHALL be preserved within each lane. No ordering SHALL be guaranteed across lanes.

Reset
REQ-025 While rst = 1, the following SHALL be cleared asynchronously:
  - both FIFO occupancies = 0 and out_0_valid = out_1_valid = 0
  - out_0_data = out_1_data = 0
  - rr_ptr = 0
  - drop_count = 0
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats. Nothing SHALL be emitted after deassertion until new input arrives.
REQ-027 in_ready SHALL follow REQ-016 from the cleared state: it is 1 for every in_dest from the first cycle after reset.

Structure
REQ-028 Package dispatcher_pkg SHALL hold the DEST_LANE0/DEST_LANE1/DEST_ANY/DEST_DROP encodings and the FIFO depth constant (2).
REQ-029 Each lane FIFO SHALL be one instance of sub-module fifo_2entry (push/pop, full/empty, head data, async active-high rst).
REQ-030 Route decode, rr_ptr and drop_count SHALL live in the top level.

Verification
REQ-031 Reset, then in_dest 01, data 0xA5, out_0_ready = 1 -> out_0_valid = 1 with data 0xA5 exactly 1 cycle later; out_1_valid remains 0.
REQ-032 out_1_ready = 0, three beats with in_dest 10 (0x01, 0x02, 0x03) -> first two accepted, in_ready = 0 on the third; after out_1_ready = 1 the lane pops 0x01 then 0x02, and 0x03 is accepted one cycle after the first pop.
REQ-033 Both lanes ready, four in_dest 11 beats 0x10..0x13 -> lane 0 gets 0x10 and 0x12, lane 1 gets 0x11 and 0x13.
REQ-034 Lane 0 full, rr_ptr = 0, in_dest 11 beat 0x77 -> goes to lane 1 and rr_ptr becomes 0; with both lanes full, in_ready = 0.
REQ-035 DROP_CNT_W = 2, five in_dest 00 beats -> in_ready = 1 throughout, no output valid, drop_count = 1, 2, 3, 3, 3.
REQ-036 rst pulse while both lanes hold 2 beats -> both valids 0, rr_ptr = 0 and drop_count = 0 immediately, with no stale beat after release.
